freq_divider_prog: RTL and testbench
====================================

Name: freq_divider_prog

Overview:
- Parametrised, fully synchronous programmable frequency divider. Generates a slow clock-enable tick and a low-frequency output from the system clock.
- The divide ratio comes from a SEL_W-bit selector placed in the upper bits of an up-counter's reload value.
- Adds enable, immediate load, a glitch-free ratio change at the period boundary, and a toggle/pulse output mode.
- The output is registered in the clock domain; no derived clocks. Feeds the lab's display/blink/timing blocks.

Parameters:
- CNT_W, 9, counter width in bits.
- SEL_W, 4, selector width; must satisfy 1 <= SEL_W < CNT_W.
- RESET_SEL, 0, selector value taken at reset.
- RESET_MODE, 0, output mode taken at reset (0 = toggle, 1 = pulse).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- enable  in  1  count enable; 0 freezes the counter and outputs.
- load  in  1  active-high synchronous load; restarts the divider immediately with par_in.
- par_in  in  SEL_W  requested divide selector.
- mode  in  1  requested output mode: 0 = toggle (50% duty), 1 = pulse.
- low_freq_clock  out  1  registered divided output.
- tick  out  1  one-cycle pulse per divider period.
- sel_active  out  SEL_W  selector currently in effect.

Behaviour:
- Definitions:
  - FRAC_W = CNT_W - SEL_W.
  - Reload value R(s) = {s, FRAC_W'b0}.
  - Terminal count TC = count is all-ones.
  - Period N(s) = 2^CNT_W - R(s) clocks.
  - Examples: s = all-ones gives N = 2^FRAC_W; s = 0 gives N = 2^CNT_W.
- Reset (reset = 0, asynchronous), all registers:
  - count = R(RESET_SEL)
  - sel_active = RESET_SEL
  - mode_active = RESET_MODE
  - low_freq_clock = 0
  - tick = 0
- Priority at each rising edge, with reset deasserted:
  1. load = 1 (ignores enable and TC):
     - sel_active <= par_in, mode_active <= mode, count <= R(par_in).
     - low_freq_clock <= 0, tick <= 0.
  2. enable = 0:
     - count, sel_active, mode_active and low_freq_clock hold; tick <= 0.
  3. enable = 1 and TC:
     - count <= R(par_in); sel_active <= par_in; mode_active <= mode; tick <= 1.
     - low_freq_clock <= ~low_freq_clock if mode_active = 0, else <= 1.
  4. enable = 1, not TC:
     - count <= count + 1 (never wraps; TC always reloads); tick <= 0.
     - low_freq_clock holds in toggle mode; in pulse mode it <= 0.
- Rules that follow from the priority order:
  - par_in and mode are sampled only at load or TC. Changes mid-period do not alter the current period, so output edges stay glitch-free.
  - In pulse mode low_freq_clock equals tick. In toggle mode the output period is 2·N, with high and low phases of N clocks each.
  - Load on the same edge as TC: load wins, no tick, output cleared.
  - enable deasserted mid-period: count freezes and the period resumes where it stopped. Total enabled cycles per tick is still N.
- Latency:
  - After a load edge with selector s and enable held high, tick first rises on the N-th subsequent edge, then every N edges.
- Reset mid-period: immediate return to reset values; the next tick comes N(RESET_SEL) enabled cycles after reset release.
- Elaboration check: SEL_W >= CNT_W is a fatal error.

Decomposition:
- Shared package freq_div_pkg:
  - MODE_TOGGLE = 1'b0, MODE_PULSE = 1'b1.
  - Function reload_val(sel), returning {sel, zeros}, parameterised by CNT_W/SEL_W.
- One sub-module, reload_counter: CNT_W up-counter with enable, synchronous reload, and a tc output.
- Top level holds the selector/mode shadow registers and the output logic.

Test Plan (defaults CNT_W = 9, SEL_W = 4, so FRAC_W = 5):
- Reset release, enable = 1, load pulse with par_in = 15, mode = 0:
  - tick every 32 clocks; low_freq_clock toggles every 32 clocks (period 64); sel_active = 15.
- load with par_in = 0, mode = 1:
  - tick and low_freq_clock pulse together, one clock high every 512 clocks.
- par_in changed 15 -> 14 mid-period, no load:
  - current period stays 32; the following periods are 64; sel_active updates at the first TC.
- enable low for 10 cycles mid-period (par_in = 15):
  - that tick arrives 42 clocks after the previous one; later ticks return to 32 apart; outputs hold while disabled.
- load asserted on the same edge as TC:
  - no tick on that edge, low_freq_clock = 0, count = R(par_in); next tick N(par_in) clocks later.
- reset driven to 0 asynchronously between edges mid-period:
  - outputs go to 0 immediately without waiting for a clock edge; after release (RESET_SEL = 0) the first tick comes 512 clocks later.

Source files
------------

// File: rtl/freq_div_pkg.sv
// Shared definitions for the programmable frequency divider.
//   MODE_TOGGLE / MODE_PULSE : output mode encodings
//   reload_val()             : counter reload value {sel, zeros} for a given selector
package freq_div_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  // Returns {sel, (cnt_w - sel_w)'b0} in the low cnt_w bits; callers truncate to CNT_W.
  // Widths are arguments so one function serves every parameterisation.
  function automatic logic [31:0] reload_val(int unsigned cnt_w, int unsigned sel_w,
                                             logic [31:0] sel);
    logic [31:0] mask;
    mask = (32'd1 << sel_w) - 32'd1;
    return (sel & mask) << (cnt_w - sel_w);
  endfunction

endpackage

// File: rtl/reload_counter.sv
// Up-counter with enable and synchronous reload.
//   clk_i, rst_ni    : clock, asynchronous active-low reset (count -> ResetVal)
//   en_i             : count enable
//   reload_i         : load reload_val_i on the next edge (overrides en_i)
//   reload_val_i     : value loaded on reload
//   tc_o             : terminal count, high while count is all-ones
module reload_counter #(
  parameter int unsigned        CntW     = 9,
  parameter logic [CntW-1:0]    ResetVal = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            reload_i,
  input  logic [CntW-1:0] reload_val_i,
  output logic            tc_o
);

  logic [CntW-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (reload_i) begin
      count_d = reload_val_i;
    end else if (en_i) begin
      // Never wraps in practice: the owner always reloads at terminal count.
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= ResetVal;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = &count_q;

endmodule

// File: rtl/freq_divider_prog.sv
// Programmable frequency divider producing a clock-enable tick and a registered
// low-frequency output. Period N(s) = 2^CNT_W - {s, FRAC_W'b0} clocks.
//   clock, reset   : system clock, asynchronous active-low reset
//   enable         : count enable; low freezes counter and outputs (tick forced low)
//   load           : synchronous restart with par_in/mode (overrides enable and TC)
//   par_in, mode   : requested selector / output mode, sampled only at load or TC
//   low_freq_clock : toggle mode -> 50% duty at 2*N; pulse mode -> equals tick
//   tick           : one-cycle pulse per divider period
//   sel_active     : selector currently in effect
module freq_divider_prog
  import freq_div_pkg::*;
#(
  parameter int unsigned CNT_W      = 9,
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned RESET_SEL  = 0,
  parameter int unsigned RESET_MODE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [SEL_W-1:0] par_in,
  input  logic             mode,
  output logic             low_freq_clock,
  output logic             tick,
  output logic [SEL_W-1:0] sel_active
);

  if (SEL_W < 1 || SEL_W >= CNT_W) begin : g_bad_params
    $fatal(1, "freq_divider_prog: SEL_W must satisfy 1 <= SEL_W < CNT_W");
  end

  localparam logic [CNT_W-1:0] ResetCount =
      CNT_W'(reload_val(CNT_W, SEL_W, 32'(RESET_SEL)));

  logic             tc;
  logic             reload;
  logic [CNT_W-1:0] load_val;

  logic [SEL_W-1:0] sel_d, sel_q;
  logic             mode_d, mode_q;
  logic             lfc_d, lfc_q;
  logic             tick_d, tick_q;

  assign load_val = CNT_W'(reload_val(CNT_W, SEL_W, 32'(par_in)));
  // Reload on explicit load or at the end of an enabled period; both use par_in.
  assign reload   = load | (enable & tc);

  reload_counter #(
    .CntW     (CNT_W),
    .ResetVal (ResetCount)
  ) u_counter (
    .clk_i        (clock),
    .rst_ni       (reset),
    .en_i         (enable),
    .reload_i     (reload),
    .reload_val_i (load_val),
    .tc_o         (tc)
  );

  always_comb begin
    sel_d  = sel_q;
    mode_d = mode_q;
    lfc_d  = lfc_q;
    tick_d = 1'b0;
    if (load) begin
      sel_d  = par_in;
      mode_d = mode;
      lfc_d  = 1'b0;
    end else if (enable) begin
      if (tc) begin
        // Ratio and mode change only here, so output edges never glitch mid-period.
        sel_d  = par_in;
        mode_d = mode;
        tick_d = 1'b1;
        lfc_d  = (mode_q == MODE_TOGGLE) ? ~lfc_q : 1'b1;
      end else if (mode_q == MODE_PULSE) begin
        lfc_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_q  <= SEL_W'(RESET_SEL);
      mode_q <= 1'(RESET_MODE);
      lfc_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      mode_q <= mode_d;
      lfc_q  <= lfc_d;
      tick_q <= tick_d;
    end
  end

  assign low_freq_clock = lfc_q;
  assign tick           = tick_q;
  assign sel_active     = sel_q;

endmodule

// File: tb/tb_freq_divider_prog.sv
module tb_freq_divider_prog;

  localparam int unsigned CNT_W  = 9;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned FRAC_W = CNT_W - SEL_W;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic             load;
  logic [SEL_W-1:0] par_in;
  logic             mode;
  logic             low_freq_clock;
  logic             tick;
  logic [SEL_W-1:0] sel_active;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: selector/mode in effect, enabled cycles into the period.
  int unsigned m_sel;
  bit          m_mode;
  bit          m_lfc;
  bit          m_tick;
  int unsigned m_elapsed;

  freq_divider_prog #(
    .CNT_W      (CNT_W),
    .SEL_W      (SEL_W),
    .RESET_SEL  (0),
    .RESET_MODE (0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .load           (load),
    .par_in         (par_in),
    .mode           (mode),
    .low_freq_clock (low_freq_clock),
    .tick           (tick),
    .sel_active     (sel_active)
  );

  always #5 clock = ~clock;

  function automatic int unsigned period(input int unsigned s);
    return (1 << CNT_W) - (s << FRAC_W);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sel     = 0;
    m_mode    = 1'b0;
    m_lfc     = 1'b0;
    m_tick    = 1'b0;
    m_elapsed = 0;
  endtask

  // One rising edge of the specified behaviour, using the inputs held across the edge.
  task automatic model_edge();
    if (load) begin
      m_sel     = par_in;
      m_mode    = mode;
      m_elapsed = 0;
      m_lfc     = 1'b0;
      m_tick    = 1'b0;
    end else if (!enable) begin
      m_tick = 1'b0;
    end else if (m_elapsed + 1 == period(m_sel)) begin
      m_tick    = 1'b1;
      m_lfc     = m_mode ? 1'b1 : ~m_lfc;
      m_sel     = par_in;
      m_mode    = mode;
      m_elapsed = 0;
    end else begin
      m_elapsed++;
      m_tick = 1'b0;
      if (m_mode) m_lfc = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check("tick", tick, m_tick);
    check("low_freq_clock", low_freq_clock, m_lfc);
    check("sel_active", sel_active, m_sel);
  endtask

  // Counts edges until tick is seen; a missing tick shows up as a wrong count.
  task automatic wait_tick(input string tag, input int exp_n);
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while (tick !== 1'b1 && c < exp_n + 20);
    check(tag, c, exp_n);
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    load   = 1'b0;
    par_in = '0;
    mode   = 1'b0;
    model_reset();
    #23;
    check("reset_tick", tick, 0);
    check("reset_lfc", low_freq_clock, 0);
    check("reset_sel", sel_active, 0);
    reset = 1'b1;

    // Toggle mode, fastest ratio.
    enable = 1'b1;
    load = 1'b1; par_in = 4'd15; mode = 1'b0;
    step();
    load = 1'b0;
    wait_tick("t1_first_tick", 32);
    check("t1_lfc_high", low_freq_clock, 1);
    wait_tick("t1_second_tick", 32);
    check("t1_lfc_low", low_freq_clock, 0);
    check("t1_sel", sel_active, 15);

    // Pulse mode, slowest ratio.
    load = 1'b1; par_in = 4'd0; mode = 1'b1;
    step();
    load = 1'b0;
    wait_tick("t2_first_tick", 512);
    check("t2_pulse_lfc", low_freq_clock, 1);
    wait_tick("t2_second_tick", 512);

    // Mid-period selector change takes effect only at the next TC.
    load = 1'b1; par_in = 4'd15; mode = 1'b0;
    step();
    load = 1'b0;
    repeat (10) step();
    par_in = 4'd14;
    check("t3_sel_unchanged", sel_active, 15);
    wait_tick("t3_current_period", 22);
    check("t3_sel_updated", sel_active, 14);
    par_in = 4'd15;
    wait_tick("t3_next_period", 64);

    // Enable stall of 10 cycles stretches one period to 42.
    repeat (5) step();
    enable = 1'b0;
    repeat (10) step();
    enable = 1'b1;
    wait_tick("t4_stalled_period", 27);
    wait_tick("t4_after_stall", 32);

    // Load on the TC edge: load wins, no tick, output cleared.
    repeat (31) step();
    load = 1'b1; par_in = 4'd14; mode = 1'b0;
    step();
    check("t5_no_tick", tick, 0);
    check("t5_lfc_clear", low_freq_clock, 0);
    load = 1'b0;
    wait_tick("t5_next_tick", 64);

    // Asynchronous reset between edges.
    load = 1'b1; par_in = 4'd15; mode = 1'b0;
    step();
    load = 1'b0;
    wait_tick("t6_pre_tick", 32);
    repeat (5) step();
    check("t6_lfc_before", low_freq_clock, 1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    model_reset();
    check("t6_async_lfc", low_freq_clock, 0);
    check("t6_async_tick", tick, 0);
    check("t6_async_sel", sel_active, 0);
    #2;
    reset = 1'b1;
    wait_tick("t6_after_reset", 512);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom % 8) != 0;
      load   = ($urandom % 64) == 0;
      par_in = SEL_W'($urandom);
      mode   = 1'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
